// File: rtl/adder_err_pkg.sv
// Shared widths, FSM state type and saturating-add helper for the adder error monitor.
package adder_err_pkg;

    localparam int unsigned OP_W  = 16;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned ACC_W = 48;
    localparam int unsigned SUM_W = OP_W + 1;
    localparam int unsigned POP_W = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } err_state_e;

    // Accumulate without wrapping: clamps to all-ones on carry out.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/adder_err_diff.sv
// Combinational error evaluation for one beat: exact sum vs. approximate sum.
// With ADDER_ERR_HAMMING_EN defined it also reports the flipped bits and their count.
module adder_err_diff
    import adder_err_pkg::*;
(
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    input  logic [SUM_W-1:0] approx_sum,
    output logic [SUM_W-1:0] diff_c,
    output logic             mismatch_c
`ifdef ADDER_ERR_HAMMING_EN
    ,
    output logic [SUM_W-1:0] flip_c,
    output logic [POP_W-1:0] popcnt_c
`endif
);

    logic [SUM_W-1:0] exact;

    // Unsigned magnitude of the error, no overflow loss in the exact sum.
    always_comb begin
        exact      = SUM_W'(op_a) + SUM_W'(op_b);
        diff_c     = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);
        mismatch_c = (diff_c != '0);
    end

`ifdef ADDER_ERR_HAMMING_EN
    always_comb begin
        flip_c   = exact ^ approx_sum;
        popcnt_c = '0;
        for (int i = 0; i < int'(SUM_W); i++) begin
            popcnt_c = popcnt_c + POP_W'(flip_c[i]);
        end
    end
`endif

endmodule

// File: rtl/adder_err_monitor.sv
// Accumulates error statistics of an approximate adder over a programmed number of beats.
// Optional Hamming statistics (ham_acc, bit_err_hist) are built when ADDER_ERR_HAMMING_EN is defined.
module adder_err_monitor
    import adder_err_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    input  logic [SUM_W-1:0] approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [SUM_W-1:0] max_abs_err
`ifdef ADDER_ERR_HAMMING_EN
    ,
    output logic [ACC_W-1:0] ham_acc,
    output logic [SUM_W-1:0] bit_err_hist
`endif
);

    err_state_e       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clear_c;
    logic             hs_c;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_v_q, s1_v_d;
    logic [OP_W-1:0]  s1_a_q, s1_a_d;
    logic [OP_W-1:0]  s1_b_q, s1_b_d;
    logic [SUM_W-1:0] s1_s_q, s1_s_d;
    logic             s2_v_q, s2_v_d;
    logic [SUM_W-1:0] s2_diff_q, s2_diff_d;
    logic             s2_mis_q, s2_mis_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] max_q, max_d;

    logic [SUM_W-1:0] diff_c;
    logic             mismatch_c;

`ifdef ADDER_ERR_HAMMING_EN
    logic [SUM_W-1:0] flip_c;
    logic [POP_W-1:0] popcnt_c;
    logic [SUM_W-1:0] s2_flip_q, s2_flip_d;
    logic [POP_W-1:0] s2_pop_q, s2_pop_d;
    logic [ACC_W-1:0] ham_q, ham_d;
    logic [SUM_W-1:0] hist_q, hist_d;
`endif

    assign hs_c = in_valid && in_ready_q;

    // Run control; registered status flags follow the next state.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        clear_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_d   = num_samples;
                    clear_c = 1'b1;
                    state_d = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (hs_c && (cnt_q + CNT_W'(1) == num_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // S2 retires on the same edge, so an empty S1 means the pipe is clear.
                if (!s1_v_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == RUN);
        busy_d     = (state_d == RUN) || (state_d == DRAIN);
        done_d     = (state_d == DONE);
    end

    adder_err_diff u_diff (
        .op_a       (s1_a_q),
        .op_b       (s1_b_q),
        .approx_sum (s1_s_q),
        .diff_c     (diff_c),
        .mismatch_c (mismatch_c)
`ifdef ADDER_ERR_HAMMING_EN
        ,
        .flip_c     (flip_c),
        .popcnt_c   (popcnt_c)
`endif
    );

    // Capture, evaluate and accumulate stages.
    always_comb begin
        cnt_d     = clear_c ? '0 : (hs_c ? cnt_q + CNT_W'(1) : cnt_q);
        s1_v_d    = hs_c;
        s1_a_d    = hs_c ? op_a : s1_a_q;
        s1_b_d    = hs_c ? op_b : s1_b_q;
        s1_s_d    = hs_c ? approx_sum : s1_s_q;
        s2_v_d    = s1_v_q;
        s2_diff_d = s1_v_q ? diff_c : s2_diff_q;
        s2_mis_d  = s1_v_q ? mismatch_c : s2_mis_q;
        err_d     = err_q;
        sum_d     = sum_q;
        max_d     = max_q;
        if (clear_c) begin
            err_d = '0;
            sum_d = '0;
            max_d = '0;
        end else if (s2_v_q) begin
            err_d = (err_q == '1) ? err_q : err_q + CNT_W'(s2_mis_q);
            sum_d = sat_add(sum_q, ACC_W'(s2_diff_q));
            max_d = (s2_diff_q > max_q) ? s2_diff_q : max_q;
        end
    end

`ifdef ADDER_ERR_HAMMING_EN
    always_comb begin
        s2_flip_d = s1_v_q ? flip_c : s2_flip_q;
        s2_pop_d  = s1_v_q ? popcnt_c : s2_pop_q;
        ham_d     = ham_q;
        hist_d    = hist_q;
        if (clear_c) begin
            ham_d  = '0;
            hist_d = '0;
        end else if (s2_v_q) begin
            ham_d  = sat_add(ham_q, ACC_W'(s2_pop_q));
            hist_d = hist_q | s2_flip_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_s_q     <= '0;
            s2_v_q     <= 1'b0;
            s2_diff_q  <= '0;
            s2_mis_q   <= 1'b0;
            err_q      <= '0;
            sum_q      <= '0;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            s1_v_q     <= s1_v_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_s_q     <= s1_s_d;
            s2_v_q     <= s2_v_d;
            s2_diff_q  <= s2_diff_d;
            s2_mis_q   <= s2_mis_d;
            err_q      <= err_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
        end
    end

`ifdef ADDER_ERR_HAMMING_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_flip_q <= '0;
            s2_pop_q  <= '0;
            ham_q     <= '0;
            hist_q    <= '0;
        end else begin
            s2_flip_q <= s2_flip_d;
            s2_pop_q  <= s2_pop_d;
            ham_q     <= ham_d;
            hist_q    <= hist_d;
        end
    end

    assign ham_acc      = ham_q;
    assign bit_err_hist = hist_q;
`endif

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = cnt_q;
    assign err_count    = err_q;
    assign sum_abs_err  = sum_q;
    assign max_abs_err  = max_q;

endmodule

// File: tb/tb_adder_err_monitor.sv
// Self-checking bench for adder_err_monitor: directed cases plus randomized runs against a
// behavioural statistics model. Hamming outputs are checked when ADDER_ERR_HAMMING_EN is defined.
module tb_adder_err_monitor;
    import adder_err_pkg::*;

    logic             clk, rst_n, start, in_valid, in_ready, busy, done;
    logic [CNT_W-1:0] num_samples, sample_count, err_count;
    logic [OP_W-1:0]  op_a, op_b;
    logic [SUM_W-1:0] approx_sum, max_abs_err;
    logic [ACC_W-1:0] sum_abs_err;
`ifdef ADDER_ERR_HAMMING_EN
    logic [ACC_W-1:0] ham_acc;
    logic [SUM_W-1:0] bit_err_hist;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [OP_W-1:0]  qa[$];
    logic [OP_W-1:0]  qb[$];
    logic [SUM_W-1:0] qs[$];

    logic [CNT_W-1:0] exp_cnt, exp_err;
    logic [ACC_W-1:0] exp_sum, exp_ham;
    logic [SUM_W-1:0] exp_max, exp_hist;

    adder_err_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .approx_sum   (approx_sum),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .sum_abs_err  (sum_abs_err),
        .max_abs_err  (max_abs_err)
`ifdef ADDER_ERR_HAMMING_EN
        ,
        .ham_acc      (ham_acc),
        .bit_err_hist (bit_err_hist)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference statistics over the first n queued beats, from plain integer arithmetic.
    task automatic compute_model(input int unsigned n);
        longint s   = 0;
        longint h   = 0;
        longint sat = (longint'(1) << ACC_W) - 1;
        int unsigned e_cnt = 0;
        int mx   = 0;
        int hist = 0;
        for (int i = 0; i < int'(n); i++) begin
            int ex, ap, d;
            ex = int'(qa[i]) + int'(qb[i]);
            ap = int'(qs[i]);
            d  = (ex > ap) ? ex - ap : ap - ex;
            if (d != 0) e_cnt++;
            s = s + longint'(d);
            if (s > sat) s = sat;
            if (d > mx) mx = d;
            h = h + longint'($countones(ex ^ ap));
            if (h > sat) h = sat;
            hist = hist | (ex ^ ap);
        end
        exp_cnt  = CNT_W'(n);
        exp_err  = CNT_W'(e_cnt);
        exp_sum  = ACC_W'(s);
        exp_max  = SUM_W'(mx);
        exp_ham  = ACC_W'(h);
        exp_hist = SUM_W'(hist);
    endtask

    task automatic clear_beats();
        qa.delete();
        qb.delete();
        qs.delete();
    endtask

    task automatic push_beat(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                             input logic [SUM_W-1:0] s);
        qa.push_back(a);
        qb.push_back(b);
        qs.push_back(s);
    endtask

    task automatic push_random_beat();
        logic [OP_W-1:0]  a, b;
        logic [SUM_W-1:0] ex, ap;
        a  = OP_W'($urandom);
        b  = OP_W'($urandom);
        ex = SUM_W'(a) + SUM_W'(b);
        case ($urandom_range(3, 0))
            0:       ap = ex;
            1:       ap = ex & ~((SUM_W'(1) << $urandom_range(8, 1)) - SUM_W'(1));
            2:       ap = SUM_W'($urandom);
            default: ap = ex + SUM_W'($urandom_range(3, 0));
        endcase
        push_beat(a, b, ap);
    endtask

    // Pulse start, offer queued beats (junk once exhausted) until done or budget runs out.
    task automatic run_beats(input int unsigned n, input bit rand_valid, output int unsigned hs);
        int unsigned idx = 0;
        int cyc = 0;
        hs = 0;
        start = 1'b1;
        num_samples = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && cyc < 4000) begin
            in_valid = rand_valid ? 1'($urandom_range(1, 0)) : 1'b1;
            if (idx < qa.size()) begin
                op_a = qa[idx]; op_b = qb[idx]; approx_sum = qs[idx];
            end else begin
                op_a = OP_W'($urandom); op_b = OP_W'($urandom); approx_sum = SUM_W'($urandom);
            end
            if (in_valid && in_ready) begin
                hs++;
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL run_timeout: done=%0b after %0d cycles, want done=1", done, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        op_a = '0; op_b = '0; approx_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%0b busy=%0b done=%0b cnt=%0d err=%0d sum=%0d max=%0d, want all 0",
                     in_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset: rdy/busy/done=%b, want 000", {in_ready, busy, done});
        end
    endtask

    task automatic test_exact_match();
        int unsigned hs;
        clear_beats();
        push_beat(16'd1, 16'd2, 17'd3);
        push_beat(16'hFFFF, 16'd1, 17'h10000);
        push_beat(16'd0, 16'd0, 17'd0);
        push_beat(16'd100, 16'd200, 17'd300);
        run_beats(4, 1'b0, hs);
        compute_model(4);
        n_cmp++;
        if (hs != 4 || exp_err != 0 || exp_sum != 0 || exp_max != 0) begin
            n_err++;
            $display("FAIL exact_match_hs: handshakes=%0d model_err=%0d, want 4 and 0", hs, exp_err);
        end
        n_cmp++;
        if ({sample_count, err_count, sum_abs_err, max_abs_err} !== {exp_cnt, exp_err, exp_sum, exp_max}) begin
            n_err++;
            $display("FAIL exact_match_stats: got cnt=%0d err=%0d sum=%0d max=%0d, want %0d %0d %0d %0d",
                     sample_count, err_count, sum_abs_err, max_abs_err, exp_cnt, exp_err, exp_sum, exp_max);
        end
    endtask

    task automatic test_truncation();
        int unsigned hs;
        clear_beats();
        push_beat(16'h000F, 16'h0001, 17'h00000);
        push_beat(16'h0013, 16'h0002, 17'h00010);
        run_beats(2, 1'b0, hs);
        compute_model(2);
        n_cmp++;
        if ({sample_count, err_count, sum_abs_err, max_abs_err} !== {32'd2, 32'd2, 48'd21, 17'd16}) begin
            n_err++;
            $display("FAIL truncation_stats: got cnt=%0d err=%0d sum=%0d max=%0d, want 2 2 21 16",
                     sample_count, err_count, sum_abs_err, max_abs_err);
        end
`ifdef ADDER_ERR_HAMMING_EN
        n_cmp++;
        if ({ham_acc, bit_err_hist} !== {exp_ham, exp_hist} || exp_hist !== 17'h15) begin
            n_err++;
            $display("FAIL truncation_hamming: got ham=%0d hist=%h, want ham=%0d hist=%h",
                     ham_acc, bit_err_hist, exp_ham, exp_hist);
        end
`endif
    endtask

    task automatic test_approx_above();
        int unsigned hs;
        clear_beats();
        push_beat(16'd5, 16'd5, 17'h1000A);
        run_beats(1, 1'b0, hs);
        n_cmp++;
        if ({sample_count, err_count, sum_abs_err, max_abs_err} !== {32'd1, 32'd1, 48'h10000, 17'h10000}) begin
            n_err++;
            $display("FAIL approx_above: got cnt=%0d err=%0d sum=%h max=%h, want 1 1 10000 10000",
                     sample_count, err_count, sum_abs_err, max_abs_err);
        end
    endtask

    task automatic test_backpressure();
        int unsigned hs = 0;
        clear_beats();
        for (int i = 0; i < 10; i++) push_random_beat();
        start = 1'b1;
        num_samples = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            op_a = qa[c]; op_b = qb[c]; approx_sum = qs[c];
            n_cmp++;
            if ({in_ready, busy, done} !== {1'(c < 3), 1'(c < 5), 1'(c >= 5)}) begin
                n_err++;
                $display("FAIL backpressure_c%0d: rdy/busy/done=%b, want %b", c,
                         {in_ready, busy, done}, {1'(c < 3), 1'(c < 5), 1'(c >= 5)});
            end
            if (in_ready) hs++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        compute_model(3);
        n_cmp++;
        if (hs != 3 || {sample_count, err_count, sum_abs_err, max_abs_err} !== {exp_cnt, exp_err, exp_sum, exp_max}) begin
            n_err++;
            $display("FAIL backpressure_stats: hs=%0d cnt=%0d err=%0d sum=%0d max=%0d, want 3 %0d %0d %0d %0d",
                     hs, sample_count, err_count, sum_abs_err, max_abs_err, exp_cnt, exp_err, exp_sum, exp_max);
        end
    endtask

    task automatic test_zero_samples();
        int unsigned hs;
        clear_beats();
        run_beats(0, 1'b0, hs);
        n_cmp++;
        if ({done, busy, sample_count, err_count, sum_abs_err, max_abs_err} !== {1'b1, 1'b0, 129'd0}) begin
            n_err++;
            $display("FAIL zero_samples: done=%0b busy=%0b cnt=%0d err=%0d sum=%0d max=%0d, want 1 0 0 0 0 0",
                     done, busy, sample_count, err_count, sum_abs_err, max_abs_err);
        end
        clear_beats();
        push_beat(16'd7, 16'd9, 17'd15);
        run_beats(1, 1'b0, hs);
        n_cmp++;
        if (hs != 1 || {sample_count, err_count, sum_abs_err, max_abs_err} !== {32'd1, 32'd1, 48'd1, 17'd1}) begin
            n_err++;
            $display("FAIL zero_then_one: hs=%0d cnt=%0d err=%0d sum=%0d max=%0d, want 1 1 1 1 1",
                     hs, sample_count, err_count, sum_abs_err, max_abs_err);
        end
    endtask

    task automatic test_reset_mid_run();
        int unsigned hs;
        clear_beats();
        for (int i = 0; i < 5; i++) push_random_beat();
        start = 1'b1;
        num_samples = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            op_a = qa[i]; op_b = qb[i]; approx_sum = qs[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (sample_count !== 32'd2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_partial: cnt=%0d busy=%0b, want 2 1", sample_count, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: rdy=%0b busy=%0b done=%0b cnt=%0d err=%0d sum=%0d max=%0d, want all 0",
                     in_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_beats();
        for (int i = 0; i < 5; i++) push_random_beat();
        run_beats(5, 1'b1, hs);
        compute_model(5);
        n_cmp++;
        if (hs != 5 || {sample_count, err_count, sum_abs_err, max_abs_err} !== {exp_cnt, exp_err, exp_sum, exp_max}) begin
            n_err++;
            $display("FAIL midrun_restart: hs=%0d cnt=%0d err=%0d sum=%0d max=%0d, want 5 %0d %0d %0d %0d",
                     hs, sample_count, err_count, sum_abs_err, max_abs_err, exp_cnt, exp_err, exp_sum, exp_max);
        end
    endtask

    task automatic test_back_to_back_random();
        int unsigned hs, n;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(24, 1);
            clear_beats();
            for (int i = 0; i < int'(n); i++) push_random_beat();
            run_beats(n, 1'(r % 2), hs);
            compute_model(n);
            n_cmp++;
            if (hs != n || {sample_count, err_count, sum_abs_err, max_abs_err} !== {exp_cnt, exp_err, exp_sum, exp_max}) begin
                n_err++;
                $display("FAIL random_run%0d: hs=%0d cnt=%0d err=%0d sum=%0d max=%0d, want %0d %0d %0d %0d %0d",
                         r, hs, sample_count, err_count, sum_abs_err, max_abs_err, n, exp_cnt, exp_err, exp_sum, exp_max);
            end
`ifdef ADDER_ERR_HAMMING_EN
            n_cmp++;
            if ({ham_acc, bit_err_hist} !== {exp_ham, exp_hist}) begin
                n_err++;
                $display("FAIL random_hamming%0d: got ham=%0d hist=%h, want ham=%0d hist=%h",
                         r, ham_acc, bit_err_hist, exp_ham, exp_hist);
            end
`endif
            repeat (2) @(posedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b1 || sample_count !== exp_cnt || max_abs_err !== exp_max) begin
                n_err++;
                $display("FAIL random_hold%0d: done=%0b cnt=%0d max=%0d, want 1 %0d %0d",
                         r, done, sample_count, max_abs_err, exp_cnt, exp_max);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_truncation();
        test_approx_above();
        test_backpressure();
        test_zero_samples();
        test_reset_mid_run();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
